// File: rtl/vjtag_pkg.sv
// Shared constants for the virtual JTAG DR controller:
// IR codes and STATUS capture bit positions.
package vjtag_pkg;

    localparam logic [1:0] IR_BYPASS = 2'b00;
    localparam logic [1:0] IR_WRITE  = 2'b01;
    localparam logic [1:0] IR_READ   = 2'b10;
    localparam logic [1:0] IR_STATUS = 2'b11;

    localparam int STAT_OVR = 17;
    localparam int STAT_WRV = 16;

endpackage

// File: rtl/vjtag_dr_ctrl_if.sv
// Fabric-side bundle of the DR controller: host-written word
// (wr_data/wr_valid/wr_ready) and host-read word (rd_data/rd_ack).
interface vjtag_dr_ctrl_if #(
    parameter int DATA_W = 32
);

    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ack;

    modport master (
        output wr_data, wr_valid, rd_ack,
        input  wr_ready, rd_data
    );

    modport slave (
        input  wr_data, wr_valid, rd_ack,
        output wr_ready, rd_data
    );

endinterface

// File: rtl/vjtag_shift_reg.sv
// DR shift register: parallel load on capture, LSB-first shift.
// Ports: clk_i, rst_ni, load_i/ld_data_i, shift_i/sin_i, q_o.
module vjtag_shift_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [DATA_W-1:0] ld_data_i,
    input  logic              shift_i,
    input  logic              sin_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] sreg_q;
    logic [DATA_W-1:0] sreg_d;

    always_comb begin
        sreg_d = sreg_q;
        if (load_i) begin
            sreg_d = ld_data_i;
        end else if (shift_i) begin
            sreg_d = {sin_i, sreg_q[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign q_o = sreg_q;

endmodule

// File: rtl/vjtag_dr_ctrl.sv
// Virtual JTAG DR controller: decodes ir_in, runs capture/shift/update.
// Ports: tck/rst_n, tdi/tdo, ir_in/ir_out, virtual_state_*, fab (master).
module vjtag_dr_ctrl
    import vjtag_pkg::*;
#(
    parameter int          DATA_W = 32,
    parameter logic [15:0] ID_VAL = 16'hA5C3
) (
    input  logic       tck,
    input  logic       rst_n,
    input  logic       tdi,
    output logic       tdo,
    input  logic [1:0] ir_in,
    output logic [1:0] ir_out,
    input  logic       virtual_state_cdr,
    input  logic       virtual_state_sdr,
    input  logic       virtual_state_udr,
    vjtag_dr_ctrl_if.master fab
);

    logic [DATA_W-1:0] sreg;
    logic [DATA_W-1:0] cap_data;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_valid_q, wr_valid_d;
    logic              overrun_q, overrun_d;
    logic              rd_ack_q, rd_ack_d;
    logic              bypass_q, bypass_d;
    logic [1:0]        ir_out_q;
    logic              upd, cap, shf;
    logic              wr_upd, wr_ok, accept;

    // udr > cdr > sdr when strobes overlap
    assign upd = virtual_state_udr;
    assign cap = virtual_state_cdr & ~upd;
    assign shf = virtual_state_sdr & ~virtual_state_cdr & ~upd;

    always_comb begin
        cap_data = '0;
        case (ir_in)
            IR_WRITE: cap_data = wr_data_q;
            IR_READ:  cap_data = fab.rd_data;
            IR_STATUS: begin
                cap_data[15:0]     = ID_VAL;
                cap_data[STAT_WRV] = wr_valid_q;
                cap_data[STAT_OVR] = overrun_q;
            end
            default:  cap_data = '0;
        endcase
    end

    // BYPASS capture only touches the bypass bit
    vjtag_shift_reg #(.DATA_W(DATA_W)) u_sreg (
        .clk_i     (tck),
        .rst_ni    (rst_n),
        .load_i    (cap & (ir_in != IR_BYPASS)),
        .ld_data_i (cap_data),
        .shift_i   (shf),
        .sin_i     (tdi),
        .q_o       (sreg)
    );

    assign accept = wr_valid_q & fab.wr_ready;
    assign wr_upd = upd & (ir_in == IR_WRITE);
    assign wr_ok  = wr_upd & (~wr_valid_q | fab.wr_ready);

    always_comb begin
        bypass_d   = bypass_q;
        wr_data_d  = wr_data_q;
        wr_valid_d = wr_valid_q;
        overrun_d  = overrun_q;
        rd_ack_d   = upd & (ir_in == IR_READ);
        if (cap & (ir_in == IR_BYPASS)) begin
            bypass_d = 1'b0;
        end else if (shf) begin
            bypass_d = tdi;
        end
        // a reload on the accept cycle keeps wr_valid high
        if (accept) begin
            wr_valid_d = 1'b0;
        end
        if (wr_ok) begin
            wr_data_d  = sreg;
            wr_valid_d = 1'b1;
        end else if (wr_upd) begin
            overrun_d = 1'b1;
        end
        if (upd & (ir_in == IR_STATUS) & sreg[0]) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            bypass_q   <= 1'b0;
            wr_data_q  <= '0;
            wr_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            rd_ack_q   <= 1'b0;
            ir_out_q   <= 2'b00;
        end else begin
            bypass_q   <= bypass_d;
            wr_data_q  <= wr_data_d;
            wr_valid_q <= wr_valid_d;
            overrun_q  <= overrun_d;
            rd_ack_q   <= rd_ack_d;
            ir_out_q   <= {overrun_q, wr_valid_q};
        end
    end

    assign tdo          = (ir_in == IR_BYPASS) ? bypass_q : sreg[0];
    assign ir_out       = ir_out_q;
    assign fab.wr_data  = wr_data_q;
    assign fab.wr_valid = wr_valid_q;
    assign fab.rd_ack   = rd_ack_q;

endmodule

// File: tb/tb_vjtag_dr_ctrl.sv
// Testbench for vjtag_dr_ctrl: directed scans plus randomized
// scans against a transaction-level model.
module tb_vjtag_dr_ctrl;

    localparam int DW = 32;

    logic       tck = 1'b0;
    logic       rst_n;
    logic       tdi;
    logic       tdo;
    logic [1:0] ir_in;
    logic [1:0] ir_out;
    logic       cdr, sdr, udr;

    vjtag_dr_ctrl_if #(.DATA_W(DW)) fab ();

    vjtag_dr_ctrl #(.DATA_W(DW), .ID_VAL(16'hA5C3)) dut (
        .tck               (tck),
        .rst_n             (rst_n),
        .tdi               (tdi),
        .tdo               (tdo),
        .ir_in             (ir_in),
        .ir_out            (ir_out),
        .virtual_state_cdr (cdr),
        .virtual_state_sdr (sdr),
        .virtual_state_udr (udr),
        .fab               (fab.master)
    );

    always #5 tck = ~tck;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] m_wdata;
    logic        m_wrv;
    logic        m_ovr;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge tck);
        #1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".wr_data"}, fab.wr_data, m_wdata);
        chk({tag, ".wr_valid"}, {31'b0, fab.wr_valid}, {31'b0, m_wrv});
        chk({tag, ".ir_out"}, {30'b0, ir_out}, {30'b0, m_ovr, m_wrv});
    endtask

    // One DR scan: capture, n shift bits of din (LSB first), optional update.
    task automatic scan(input logic [1:0] ir, input int n,
                        input logic [31:0] din, input logic [31:0] rdd,
                        input bit do_upd, input bit rdy);
        logic [31:0] cap;
        logic [63:0] cat;
        logic [31:0] fin;
        logic        expb;
        case (ir)
            2'b01:   cap = m_wdata;
            2'b10:   cap = rdd;
            2'b11:   cap = {14'b0, m_ovr, m_wrv, 16'hA5C3};
            default: cap = '0;
        endcase
        ir_in = ir;
        fab.rd_data = rdd;
        cdr = 1'b1;
        tick();
        cdr = 1'b0;
        for (int i = 0; i < n; i++) begin
            tdi = din[i];
            sdr = 1'b1;
            if (ir == 2'b00) begin
                if (i == 0) expb = 1'b0;
                else        expb = din[i-1];
            end else begin
                expb = cap[i];
            end
            chk($sformatf("tdo[ir%0d,b%0d]", ir, i), {31'b0, tdo},
                {31'b0, expb});
            tick();
        end
        sdr = 1'b0;
        tdi = 1'b0;
        cat = {din, cap};
        fin = cat[n +: 32];
        if (do_upd) begin
            udr = 1'b1;
            fab.wr_ready = rdy;
            tick();
            udr = 1'b0;
            fab.wr_ready = 1'b0;
            if (ir == 2'b01) begin
                if (!m_wrv || rdy) begin
                    m_wdata = fin;
                    m_wrv = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else begin
                if (m_wrv && rdy) m_wrv = 1'b0;
                if (ir == 2'b11 && fin[0]) m_ovr = 1'b0;
            end
            chk("rd_ack", {31'b0, fab.rd_ack}, {31'b0, ir == 2'b10});
            tick();
            chk("rd_ack_end", {31'b0, fab.rd_ack}, 32'd0);
        end else begin
            tick();
        end
        check_state($sformatf("scan_ir%0d", ir));
    endtask

    task automatic accept;
        fab.wr_ready = 1'b1;
        tick();
        fab.wr_ready = 1'b0;
        m_wrv = 1'b0;
        tick();
        check_state("accept");
    endtask

    task automatic reset_mid_scan;
        ir_in = 2'b11;
        cdr = 1'b1;
        tick();
        cdr = 1'b0;
        sdr = 1'b1;
        tdi = 1'b1;
        repeat (5) tick();
        rst_n = 1'b0;
        #2;
        m_wdata = '0;
        m_wrv = 1'b0;
        m_ovr = 1'b0;
        check_state("rst_mid");
        chk("rst_mid.tdo", {31'b0, tdo}, 32'd0);
        chk("rst_mid.rd_ack", {31'b0, fab.rd_ack}, 32'd0);
        sdr = 1'b0;
        tdi = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        tdi = 1'b0;
        ir_in = 2'b00;
        cdr = 1'b0;
        sdr = 1'b0;
        udr = 1'b0;
        fab.wr_ready = 1'b0;
        fab.rd_data = '0;
        m_wdata = '0;
        m_wrv = 1'b0;
        m_ovr = 1'b0;
        #12;
        check_state("reset");
        chk("reset.tdo", {31'b0, tdo}, 32'd0);
        chk("reset.rd_ack", {31'b0, fab.rd_ack}, 32'd0);
        @(posedge tck);
        #1;
        rst_n = 1'b1;

        scan(2'b11, 32, 32'h0, 32'h0, 1'b1, 1'b0);
        scan(2'b01, 32, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0);
        scan(2'b01, 32, 32'h12345678, 32'h0, 1'b1, 1'b0);
        scan(2'b11, 32, 32'h1, 32'h0, 1'b1, 1'b0);
        scan(2'b10, 32, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0);
        scan(2'b00, 4, 32'hB, 32'h0, 1'b1, 1'b0);
        scan(2'b01, 32, 32'h1, 32'h0, 1'b1, 1'b1);
        accept();

        for (int k = 0; k < 60; k++) begin
            scan(2'($urandom_range(0, 3)), $urandom_range(1, 32),
                 $urandom, $urandom, $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) accept();
        end

        scan(2'b01, 32, 32'h55AA55AA, 32'h0, 1'b1, 1'b0);
        reset_mid_scan();
        scan(2'b11, 32, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
